// File: rtl/uart_rx2_if.sv
// Receive-side bundle of the uart_mirror path: serial line in,
// byte strobe and status out.
interface uart_rx2_if;
  logic       RX_DATA;
  logic       RX_DV;
  logic [7:0] RX_BYTE;
  logic       FRAME_ERR;
  logic       BUSY;

  modport master (
    input  RX_DATA,
    output RX_DV,
    output RX_BYTE,
    output FRAME_ERR,
    output BUSY
  );

  modport slave (
    output RX_DATA,
    input  RX_DV,
    input  RX_BYTE,
    input  FRAME_ERR,
    input  BUSY
  );
endinterface

// File: rtl/uart_rx2.sv
// 8N1 UART receiver with start-glitch rejection, framing-error
// pulse and break hold-off; mid-bit sampling off a 2-flop synchroniser.
module uart_rx2 #(
  parameter int UART_BAUD    = 9600,
  parameter int CLKS_PER_BIT = 12_000_000 / UART_BAUD
) (
  input logic        CLK,
  input logic        RST_N,
  uart_rx2_if.master bus
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW       = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] HALF_M1 = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    byte_q, byte_d;
  logic          dv_q, dv_d;
  logic          ferr_q, ferr_d;
  logic          sync1_q, sync2_q;
  logic          rx_s;

  // Synchroniser resets high so reset never looks like a start edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= bus.RX_DATA;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s = sync2_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      dv_q    <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      dv_q    <= dv_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    dv_d    = 1'b0;
    ferr_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!rx_s) state_d = START;
      end

      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d          = '0;
          shift_d[bit_q] = rx_s;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = CLEANUP;
          if (rx_s) begin
            byte_d = shift_q;
            dv_d   = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Holds off a break until the line is released.
      CLEANUP: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        bit_d   = '0;
      end
    endcase
  end

  assign bus.RX_DV     = dv_q;
  assign bus.FRAME_ERR = ferr_q;
  assign bus.RX_BYTE   = byte_q;
  assign bus.BUSY      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx2.sv
// Self-checking bench for uart_rx2: directed frames plus random
// traffic against an event-time reference model.
module tb_uart_rx2;

  localparam int CPB   = 16;
  localparam int HALF  = CPB / 2;
  localparam int LAT   = 2 + HALF + 9 * CPB;

  typedef struct {
    int         cyc;
    bit         err;
    logic [7:0] b;
  } ev_t;

  logic CLK = 1'b0;
  logic RST_N;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  int   last_dv = -100;
  logic [7:0] model_byte;
  ev_t  exp_q[$];

  uart_rx2_if bus();

  uart_rx2 #(.CLKS_PER_BIT(CPB)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)",
               tag, got, exp, cyc);
    end
  endtask

  // Pulse monitor: every strobe must match the head of the model queue.
  always @(negedge CLK) begin
    if (bus.RX_DV || bus.FRAME_ERR) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {bus.RX_DV, bus.FRAME_ERR}, 2'b00);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("pulse_cyc", cyc, e.cyc);
        chk("pulse_kind", {bus.RX_DV, bus.FRAME_ERR},
            e.err ? 2'b01 : 2'b10);
        if (!e.err) model_byte = e.b;
        chk("rx_byte", bus.RX_BYTE, model_byte);
      end
    end
    if (bus.RX_DV) begin
      chk("busy_at_dv", bus.BUSY, 1);
      last_dv = cyc;
    end
    if (cyc == last_dv + 2) chk("busy_fall", bus.BUSY, 0);
  end

  // Drives the first nbits of a frame (10 = whole frame); caller is at a negedge.
  task automatic send_frame(input logic [7:0] b, input bit stop,
                            input int nbits);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    if (nbits == 10) exp_q.push_back('{cyc + 1 + LAT, !stop, b});
    for (int i = 0; i < nbits; i++) begin
      bus.RX_DATA = fr[i];
      repeat (CPB) @(negedge CLK);
    end
  endtask

  task automatic idle(input int n);
    bus.RX_DATA = 1'b1;
    repeat (n) @(negedge CLK);
  endtask

  task automatic glitch(input int len);
    int e0;
    e0 = cyc + 1;
    bus.RX_DATA = 1'b0;
    repeat (len) @(negedge CLK);
    bus.RX_DATA = 1'b1;
    while (cyc < e0 + 10) @(negedge CLK);
    chk("glitch_busy", bus.BUSY, 0);
  endtask

  initial begin
    logic acc;
    int   er;
    model_byte  = 8'h00;
    RST_N       = 1'b0;
    bus.RX_DATA = 1'b1;
    repeat (5) @(negedge CLK);
    RST_N = 1'b1;

    acc = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      acc = acc | bus.RX_DV | bus.FRAME_ERR | bus.BUSY;
    end
    chk("reset_idle_flags", acc, 0);
    chk("reset_byte", bus.RX_BYTE, 8'h00);

    send_frame(8'hA5, 1'b1, 10);
    idle(20);

    glitch(3);
    idle(16);

    send_frame(8'h3C, 1'b0, 10);
    bus.RX_DATA = 1'b0;
    repeat (40 * CPB) @(negedge CLK);
    chk("break_busy", bus.BUSY, 1);
    er = cyc + 1;
    bus.RX_DATA = 1'b1;
    while (cyc < er + 1) @(negedge CLK);
    chk("break_busy_hold", bus.BUSY, 1);
    @(negedge CLK);
    chk("break_release", bus.BUSY, 0);
    chk("break_byte", bus.RX_BYTE, 8'hA5);
    idle(20);

    send_frame(8'h00, 1'b1, 10);
    send_frame(8'hFF, 1'b1, 10);
    send_frame(8'h55, 1'b1, 10);
    idle(20);

    send_frame(8'h5A, 1'b1, 10);
    idle(4);
    send_frame(8'hC3, 1'b1, 5);
    bus.RX_DATA = 1'b1;
    repeat (HALF) @(negedge CLK);
    RST_N = 1'b0;
    #1;
    chk("rst_dv", bus.RX_DV, 0);
    chk("rst_ferr", bus.FRAME_ERR, 0);
    chk("rst_busy", bus.BUSY, 0);
    chk("rst_byte", bus.RX_BYTE, 8'h00);
    model_byte = 8'h00;
    @(negedge CLK);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    idle(20);
    send_frame(8'h81, 1'b1, 10);
    idle(20);

    for (int n = 0; n < 14; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        glitch($urandom_range(1, HALF - 1));
        idle(16);
      end else begin
        logic [7:0] b;
        bit         st;
        b  = 8'($urandom);
        st = ($urandom_range(0, 5) != 0);
        send_frame(b, st, 10);
        if (st) idle($urandom_range(0, 20));
        else    idle($urandom_range(16, 40));
      end
    end

    idle(LAT + 40);
    chk("model_drained", exp_q.size(), 0);
    chk("final_busy", bus.BUSY, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
